// File: rtl/ctrl_seq_decoder.sv
// Control-word sequence decoder: tracks the step 0..7 order and counts completed frames.
// Optional build macro: CTRL_SEQ_DECODER_ERR_COUNT_EN adds a saturating error counter on err_count.
module ctrl_seq_decoder #(
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ctrl_valid,
  input  logic [6:0]             ctrl_word,
  input  logic                   err_clr,
  output logic [2:0]             step,
  output logic                   step_valid,
  output logic                   locked,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic                   seq_err
`ifdef CTRL_SEQ_DECODER_ERR_COUNT_EN
  ,
  output logic [7:0]             err_count
`endif
);

  typedef enum logic [1:0] {
    S_HUNT  = 2'd0,
    S_TRACK = 2'd1,
    S_ERR   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [2:0]             r_expected;
  logic [2:0]             w_expected_nxt;
  logic [2:0]             r_step;
  logic                   r_step_valid;
  logic                   r_locked;
  logic                   r_frame_done;
  logic [FRAME_CNT_W-1:0] r_frame_count;
  logic                   r_seq_err;
  logic                   w_legal;
  logic [2:0]             w_dec;
  logic                   w_accept;
  logic                   w_err_hit;
  logic                   w_frame_hit;

  always_comb begin
    w_legal = 1'b1;
    w_dec   = 3'd0;
    case (ctrl_word)
      7'b1010101: w_dec = 3'd0;
      7'b1111111: w_dec = 3'd1;
      7'b1111110: w_dec = 3'd2;
      7'b1111100: w_dec = 3'd3;
      7'b1111000: w_dec = 3'd4;
      7'b1110000: w_dec = 3'd5;
      7'b1100000: w_dec = 3'd6;
      7'b1000000: w_dec = 3'd7;
      default:    w_legal = 1'b0;
    endcase
  end

  assign w_accept = ctrl_valid & w_legal;

  always_comb begin
    w_state_nxt    = r_state;
    w_expected_nxt = r_expected;
    w_err_hit      = 1'b0;
    w_frame_hit    = 1'b0;
    case (r_state)
      S_HUNT: begin
        if (ctrl_valid) begin
          if (!w_legal) begin
            w_state_nxt = S_ERR;
            w_err_hit   = 1'b1;
          end else if (w_dec <= 3'd1) begin
            w_state_nxt    = S_TRACK;
            w_expected_nxt = w_dec + 3'd1;
          end
        end
      end
      S_TRACK: begin
        if (ctrl_valid) begin
          if (w_legal && (w_dec == r_expected)) begin
            // 3-bit add wraps 7 -> 0, so step 0 is the only in-order word after 7
            w_expected_nxt = w_dec + 3'd1;
            w_frame_hit    = (w_dec == 3'd7);
          end else begin
            w_state_nxt = S_ERR;
            w_err_hit   = 1'b1;
          end
        end
      end
      S_ERR: begin
        w_state_nxt    = S_HUNT;
        w_expected_nxt = 3'd0;
      end
      default: begin
        w_state_nxt    = S_HUNT;
        w_expected_nxt = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_HUNT;
      r_expected    <= 3'd0;
      r_step        <= 3'd0;
      r_step_valid  <= 1'b0;
      r_locked      <= 1'b0;
      r_frame_done  <= 1'b0;
      r_frame_count <= '0;
      r_seq_err     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_expected   <= w_expected_nxt;
      r_step_valid <= w_accept;
      r_locked     <= (w_state_nxt == S_TRACK);
      r_frame_done <= w_frame_hit;
      if (w_accept) begin
        r_step <= w_dec;
      end
      if (w_frame_hit) begin
        r_frame_count <= r_frame_count + FRAME_CNT_W'(1);
      end
      // a new error wins over a simultaneous clear
      if (w_err_hit) begin
        r_seq_err <= 1'b1;
      end else if (err_clr) begin
        r_seq_err <= 1'b0;
      end
    end
  end

`ifdef CTRL_SEQ_DECODER_ERR_COUNT_EN
  logic [7:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= 8'd0;
    end else if (w_err_hit) begin
      if (err_clr) begin
        r_err_count <= 8'd1;
      end else if (r_err_count != 8'hFF) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end else if (err_clr) begin
      r_err_count <= 8'd0;
    end
  end

  assign err_count = r_err_count;
`endif

  assign step        = r_step;
  assign step_valid  = r_step_valid;
  assign locked      = r_locked;
  assign frame_done  = r_frame_done;
  assign frame_count = r_frame_count;
  assign seq_err     = r_seq_err;

endmodule
